instr_mem_loadable: RTL and testbench
=====================================

Name: instr_mem_loadable

Overview:
Parametrised instruction memory for the ARM pipeline fetch stage. It has a registered (one-cycle) read port with stall and flush, and a runtime program-load port that writes words sequentially under a valid/ready handshake. Out-of-range or misaligned fetches are flagged, not aliased. It replaces the fixed, combinational, hard-coded program ROM, so the bench can load programs without editing RTL.

Parameters:
DEPTH, 64, number of 32-bit instruction words (need not be a power of two)
ADDR_W, 32, width of pc
IDX_W, 6, width of word index and load pointer; must satisfy 2^IDX_W >= DEPTH
NOP_WORD, 32'hE1A00000, word driven when no valid instruction is available (MOV r0,r0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
pc  in  ADDR_W  byte address of fetch
fetch_req  in  1  fetch request this cycle
freeze  in  1  hold current inst/inst_valid/fault (hazard stall)
flush  in  1  squash the fetch result (branch taken)
inst  out  32  fetched instruction, registered
inst_valid  out  1  inst holds a real fetch result
fault  out  1  registered with inst: the fetch was misaligned or out of range
ld_start  in  1  begin a program load
ld_base  in  IDX_W  first word index of the load
ld_valid  in  1  ld_data is valid
ld_data  in  32  word to write
ld_last  in  1  qualifies the final word of the load
ld_ready  out  1  block accepts a load word this cycle
ld_done  out  1  one-cycle pulse after the last word is accepted
ld_err  out  1  sticky: at least one load word targeted an index >= DEPTH
busy  out  1  high while in LOAD

Behaviour:
- FSM states: RUN, LOAD. Reset sends the FSM to RUN.
- Reset values:
  - inst=NOP_WORD, inst_valid=0, fault=0.
  - ld_ready=0, ld_done=0, ld_err=0, busy=0.
  - Load pointer = 0.
  - Memory contents are NOT cleared by reset.
- RUN fetch, one-cycle latency. Priority is flush > freeze > fetch_req. Outputs update on the edge after sampling:
  - flush=1: inst=NOP_WORD, inst_valid=0, fault=0. flush overrides freeze.
  - else freeze=1: inst, inst_valid and fault all hold.
  - else fetch_req=0: inst_valid=0, inst=NOP_WORD, fault=0.
  - else, with idx = pc>>2:
    - pc[1:0]!=0 or idx>=DEPTH: inst=NOP_WORD, inst_valid=1, fault=1.
    - otherwise: inst=mem[idx], inst_valid=1, fault=0.
  - The range compare uses the full ADDR_W-2 index; upper pc bits are never truncated or aliased.
- RUN -> LOAD: on ld_start=1.
  - Pointer <= ld_base, ld_err <= 0.
  - A fetch sampled in that same cycle completes normally from the old contents.
- In LOAD:
  - busy=1, ld_ready=1.
  - Fetch port output each cycle: inst=NOP_WORD, inst_valid=0, fault=0. fetch_req, freeze and flush are ignored.
  - ld_start is ignored.
- Load beat = ld_valid && ld_ready.
  - If pointer<DEPTH: mem[pointer] <= ld_data.
  - Otherwise the write is dropped and ld_err <= 1.
  - After each beat, pointer increments by 1. It saturates at 2^IDX_W-1 and does not wrap; ld_err stays set.
- Beat with ld_last=1:
  - Next cycle: FSM=RUN, ld_done=1 for exactly one cycle, ld_ready=0, busy=0.
  - ld_last without ld_valid has no effect.
- ld_valid=0 in LOAD: no write, pointer holds, FSM stays in LOAD indefinitely.
- rst mid-LOAD: FSM -> RUN, pointer=0, ld_err=0. Words already written remain in memory.
- ld_err holds its value in RUN until the next ld_start or rst.
- A fetch in the first RUN cycle after ld_done sees the newly loaded data.

Test Plan:
- Reset, then load 4 words from ld_base=0: E3A00014, E3A01A01, E3A02103, E0923000, last on beat 4. Expect ld_done pulses once, busy is 1 for exactly 4 cycles, then fetches at pc=0,4,8,12 return those words one cycle later with inst_valid=1, fault=0.
- Fetch pc=2 -> next cycle inst=E1A00000, inst_valid=1, fault=1. Fetch pc=256 with DEPTH=64 -> same result. Fetch pc=32'h0001_0000 -> fault=1, no aliasing to index 0.
- Fetch pc=4 then freeze for 3 cycles while pc changes to 8,12,16 -> inst holds E3A01A01 throughout. Assert freeze+flush together -> next cycle inst_valid=0, inst=E1A00000.
- Load starting ld_base=62 with 4 beats at DEPTH=64 -> mem[62], mem[63] written, ld_err=1 after beat 3. Fetch pc=248 returns beat-1 data. ld_err clears on the next ld_start.
- Load with ld_valid toggling 1,0,0,1,1 (last on the final beat) -> exactly 3 words written at consecutive indices. fetch_req=1 throughout yields inst_valid=0 during LOAD.
- Assert rst after 2 of 5 load beats -> FSM in RUN, busy=0, ld_err=0. Those 2 words are readable; old contents at the next 3 indices are unchanged.

Source files
------------

// File: rtl/instr_mem_loadable_if.sv
// Bus bundle for the loadable instruction memory: fetch port and program-load port.
// The master side is the fetch stage / loader, the slave side is the memory.
interface instr_mem_loadable_if #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6
);
    // fetch port
    logic [ADDR_W-1:0] pc;
    logic              fetch_req;
    logic              freeze;
    logic              flush;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              fault;

    // program-load port
    logic              ld_start;
    logic [IDX_W-1:0]  ld_base;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic              ld_err;
    logic              busy;

    modport master (
        output pc, fetch_req, freeze, flush,
        output ld_start, ld_base, ld_valid, ld_data, ld_last,
        input  inst, inst_valid, fault,
        input  ld_ready, ld_done, ld_err, busy
    );

    modport slave (
        input  pc, fetch_req, freeze, flush,
        input  ld_start, ld_base, ld_valid, ld_data, ld_last,
        output inst, inst_valid, fault,
        output ld_ready, ld_done, ld_err, busy
    );
endinterface

// File: rtl/instr_mem_loadable.sv
// Instruction memory with a registered, stallable fetch port and a runtime
// sequential program-load port; bad fetches are flagged rather than aliased.
module instr_mem_loadable #(
    parameter int          DEPTH    = 64,
    parameter int          ADDR_W   = 32,
    parameter int          IDX_W    = 6,
    parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
    input logic                 clk,
    input logic                 rst,
    instr_mem_loadable_if.slave bus
);

    localparam int                FULL_IDX_W = ADDR_W - 2;
    localparam logic [FULL_IDX_W-1:0] DEPTH_IDX = FULL_IDX_W'(DEPTH);
    localparam logic [IDX_W:0]        DEPTH_PTR = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]      PTR_MAX   = '1;

    typedef enum logic {
        RUN,
        LOAD
    } state_t;

    state_t state_q, state_d;

    logic [31:0]      mem [DEPTH];

    logic [31:0]      inst_q, inst_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;

    logic [IDX_W-1:0] ptr_q;
    logic             ovf_q;       // pointer has run past the top of the index space
    logic             err_q;
    logic             done_q;

    logic [FULL_IDX_W-1:0] pc_idx;
    logic                  pc_bad;
    logic                  ptr_ok;
    logic                  in_load;
    logic                  beat;

    assign in_load = (state_q == LOAD);
    assign beat    = in_load && bus.ld_valid;
    assign pc_idx  = bus.pc[ADDR_W-1:2];
    assign pc_bad  = (bus.pc[1:0] != 2'b00) || (pc_idx >= DEPTH_IDX);
    assign ptr_ok  = !ovf_q && ({1'b0, ptr_q} < DEPTH_PTR);

    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.ld_start)          state_d = LOAD;
            LOAD:    if (beat && bus.ld_last)   state_d = RUN;
            default:                            state_d = RUN;
        endcase
    end

    // Fetch result for the next edge; flush beats freeze beats fetch_req.
    always_comb begin
        inst_d  = inst_q;
        valid_d = valid_q;
        fault_d = fault_q;
        if (in_load || bus.flush || (!bus.freeze && !bus.fetch_req)) begin
            inst_d  = NOP_WORD;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (!bus.freeze) begin
            valid_d = 1'b1;
            if (pc_bad) begin
                inst_d  = NOP_WORD;
                fault_d = 1'b1;
            end else begin
                inst_d  = mem[pc_idx[IDX_W-1:0]];
                fault_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            inst_q  <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            done_q  <= beat && bus.ld_last;

            if (!in_load && bus.ld_start) begin
                ptr_q <= bus.ld_base;
                ovf_q <= 1'b0;
                err_q <= 1'b0;
            end else if (beat) begin
                if (!ptr_ok) begin
                    err_q <= 1'b1;
                end
                // Saturate instead of wrapping so late beats never hit low indices.
                if (ptr_q == PTR_MAX) begin
                    ovf_q <= 1'b1;
                end else begin
                    ptr_q <= ptr_q + IDX_W'(1);
                end
            end
        end
    end

    // NOTE: the storage array has no reset; loaded programs survive rst, and a
    // reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && beat && ptr_ok) begin
            mem[ptr_q] <= bus.ld_data;
        end
    end

    assign bus.inst       = inst_q;
    assign bus.inst_valid = valid_q;
    assign bus.fault      = fault_q;
    assign bus.ld_ready   = in_load;
    assign bus.busy       = in_load;
    assign bus.ld_done    = done_q;
    assign bus.ld_err     = err_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable: table-driven fetch vectors scored
// through a queue, plus hand-written load, overflow, toggle and reset sequences.
module tb_instr_mem_loadable;

    localparam logic [31:0] NOP = 32'hE1A00000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_mem_loadable_if #(.ADDR_W(32), .IDX_W(6)) bus ();

    instr_mem_loadable #(
        .DEPTH(64), .ADDR_W(32), .IDX_W(6), .NOP_WORD(32'hE1A00000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        req;
        logic        frz;
        logic        fl;
        logic [31:0] e_inst;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    vec_t vt[18];

    int total = 0;
    int bad   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    logic [31:0] lw [8];
    logic        lv [8];
    logic        ll [8];
    logic        le [8];

    always @(posedge clk) begin
        if (bus.busy)    busy_cnt <= busy_cnt + 1;
        if (bus.ld_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        bus.pc        = v.pc;
        bus.fetch_req = v.req;
        bus.freeze    = v.frz;
        bus.flush     = v.fl;
        sb.push_back('{v.name, v.e_inst, v.e_valid, v.e_fault});
        tick();
        e = sb.pop_front();
        check($sformatf("%s.inst", e.name),  bus.inst,       e.inst);
        check($sformatf("%s.valid", e.name), 32'(bus.inst_valid), 32'(e.valid));
        check($sformatf("%s.fault", e.name), 32'(bus.fault),      32'(e.fault));
    endtask

    task automatic fetch(input string name, input logic [31:0] pc, input logic [31:0] e_inst);
        apply('{name, pc, 1'b1, 1'b0, 1'b0, e_inst, 1'b1, 1'b0});
    endtask

    // Drives ld_start, then n slots from lw/lv/ll; ends in the cycle ld_done should be high.
    task automatic do_load(input string name, input logic [5:0] base, input int n,
                           input bit chk_err, input bit chk_fetch);
        bus.ld_start = 1'b1;
        bus.ld_base  = base;
        tick();
        bus.ld_start = 1'b0;
        for (int s = 0; s < n; s++) begin
            check($sformatf("%s.busy%0d", name, s),  32'(bus.busy),     32'd1);
            check($sformatf("%s.ready%0d", name, s), 32'(bus.ld_ready), 32'd1);
            if (chk_err)
                check($sformatf("%s.err%0d", name, s), 32'(bus.ld_err), 32'(le[s]));
            if (chk_fetch)
                check($sformatf("%s.ivalid%0d", name, s), 32'(bus.inst_valid), (s == 0) ? 32'd1 : 32'd0);
            bus.ld_valid = lv[s];
            bus.ld_data  = lw[s];
            bus.ld_last  = ll[s];
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check($sformatf("%s.done", name),  32'(bus.ld_done),  32'd1);
        check($sformatf("%s.busy_end", name), 32'(bus.busy),  32'd0);
        check($sformatf("%s.ready_end", name), 32'(bus.ld_ready), 32'd0);
        if (chk_fetch)
            check($sformatf("%s.ivalid_end", name), 32'(bus.inst_valid), 32'd0);
    endtask

    initial begin
        int b0, d0;

        vt[0]  = '{"rd0",      32'h0000_0000, 1, 0, 0, 32'hE3A00014, 1, 0};
        vt[1]  = '{"rd4",      32'h0000_0004, 1, 0, 0, 32'hE3A01A01, 1, 0};
        vt[2]  = '{"rd8",      32'h0000_0008, 1, 0, 0, 32'hE3A02103, 1, 0};
        vt[3]  = '{"rd12",     32'h0000_000C, 1, 0, 0, 32'hE0923000, 1, 0};
        vt[4]  = '{"misal",    32'h0000_0002, 1, 0, 0, NOP,          1, 1};
        vt[5]  = '{"oor256",   32'h0000_0100, 1, 0, 0, NOP,          1, 1};
        vt[6]  = '{"noalias",  32'h0001_0000, 1, 0, 0, NOP,          1, 1};
        vt[7]  = '{"noreq",    32'h0000_0000, 0, 0, 0, NOP,          0, 0};
        vt[8]  = '{"rd4b",     32'h0000_0004, 1, 0, 0, 32'hE3A01A01, 1, 0};
        vt[9]  = '{"frz8",     32'h0000_0008, 1, 1, 0, 32'hE3A01A01, 1, 0};
        vt[10] = '{"frz12",    32'h0000_000C, 1, 1, 0, 32'hE3A01A01, 1, 0};
        vt[11] = '{"frz16",    32'h0000_0010, 1, 1, 0, 32'hE3A01A01, 1, 0};
        vt[12] = '{"frzflush", 32'h0000_0010, 1, 1, 1, NOP,          0, 0};
        vt[13] = '{"misal2",   32'h0000_0002, 1, 0, 0, NOP,          1, 1};
        vt[14] = '{"frzfault", 32'h0000_0000, 1, 1, 0, NOP,          1, 1};
        vt[15] = '{"topaddr",  32'hFFFF_FFFC, 1, 0, 0, NOP,          1, 1};
        vt[16] = '{"flush",    32'h0000_0000, 1, 0, 1, NOP,          0, 0};
        vt[17] = '{"rd0b",     32'h0000_0000, 1, 0, 0, 32'hE3A00014, 1, 0};

        rst = 1'b1;
        bus.pc = '0; bus.fetch_req = 0; bus.freeze = 0; bus.flush = 0;
        bus.ld_start = 0; bus.ld_base = '0; bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;
        tick();
        tick();
        check("rst.inst",  bus.inst,               NOP);
        check("rst.valid", 32'(bus.inst_valid),    32'd0);
        check("rst.fault", 32'(bus.fault),         32'd0);
        check("rst.ready", 32'(bus.ld_ready),      32'd0);
        check("rst.done",  32'(bus.ld_done),       32'd0);
        check("rst.err",   32'(bus.ld_err),        32'd0);
        check("rst.busy",  32'(bus.busy),          32'd0);
        rst = 1'b0;
        tick();

        // Four-word program at index 0; first fetch issued in the ld_done cycle.
        lw[0] = 32'hE3A00014; lw[1] = 32'hE3A01A01; lw[2] = 32'hE3A02103; lw[3] = 32'hE0923000;
        for (int i = 0; i < 4; i++) begin lv[i] = 1; ll[i] = (i == 3); end
        b0 = busy_cnt; d0 = done_cnt;
        do_load("load4", 6'd0, 4, 0, 0);
        check("load4.busy_cycles", 32'(busy_cnt - b0), 32'd4);
        for (int i = 0; i < 18; i++) apply(vt[i]);
        check("load4.done_pulses", 32'(done_cnt - d0), 32'd1);
        check("load4.done_low",    32'(bus.ld_done),   32'd0);

        // Overflow past DEPTH: two writes, then sticky error, no wrap to index 0.
        for (int i = 0; i < 4; i++) begin
            lw[i] = 32'hA0A0_0000 + 32'(i); lv[i] = 1; ll[i] = (i == 3); le[i] = (i == 3);
        end
        do_load("ovf", 6'd62, 4, 1, 0);
        check("ovf.err_end", 32'(bus.ld_err), 32'd1);
        fetch("ovf.rd248", 32'd248, 32'hA0A0_0000);
        fetch("ovf.rd252", 32'd252, 32'hA0A0_0001);
        fetch("ovf.rd0",   32'd0,   32'hE3A00014);
        check("ovf.err_sticky", 32'(bus.ld_err), 32'd1);
        lw[0] = 32'hE3A00014; lv[0] = 1; ll[0] = 1; le[0] = 0;
        do_load("reload", 6'd0, 1, 1, 0);
        check("reload.err", 32'(bus.ld_err), 32'd0);

        // Known background at indices 8..15.
        for (int i = 0; i < 8; i++) begin
            lw[i] = 32'hC0C0_0000 + 32'(i); lv[i] = 1; ll[i] = (i == 7);
        end
        do_load("fill", 6'd8, 8, 0, 0);

        // Gapped load with a stray ld_last on an idle slot; fetch held requested.
        lw[0] = 32'hB0B0_0000; lw[1] = 32'hDEAD_0001; lw[2] = 32'hDEAD_0002;
        lw[3] = 32'hB0B0_0003; lw[4] = 32'hB0B0_0004;
        lv[0] = 1; lv[1] = 0; lv[2] = 0; lv[3] = 1; lv[4] = 1;
        ll[0] = 0; ll[1] = 1; ll[2] = 0; ll[3] = 0; ll[4] = 1;
        bus.pc = 32'd0; bus.fetch_req = 1; bus.freeze = 0; bus.flush = 0;
        do_load("toggle", 6'd8, 5, 0, 1);
        fetch("toggle.rd32", 32'd32, 32'hB0B0_0000);
        fetch("toggle.rd36", 32'd36, 32'hB0B0_0003);
        fetch("toggle.rd40", 32'd40, 32'hB0B0_0004);
        fetch("toggle.rd44", 32'd44, 32'hC0C0_0003);

        // Reset after two of five beats; the beat presented with rst is discarded.
        bus.fetch_req = 0;
        bus.ld_start = 1; bus.ld_base = 6'd11;
        tick();
        bus.ld_start = 0;
        bus.ld_valid = 1; bus.ld_data = 32'hD0D0_0000; tick();
        bus.ld_data = 32'hD0D0_0001; tick();
        bus.ld_data = 32'hDEAD_BEEF; rst = 1; tick();
        rst = 0; bus.ld_valid = 0;
        check("rstld.busy",  32'(bus.busy),       32'd0);
        check("rstld.ready", 32'(bus.ld_ready),   32'd0);
        check("rstld.err",   32'(bus.ld_err),     32'd0);
        check("rstld.done",  32'(bus.ld_done),    32'd0);
        check("rstld.inst",  bus.inst,            NOP);
        fetch("rstld.rd44", 32'd44, 32'hD0D0_0000);
        fetch("rstld.rd48", 32'd48, 32'hD0D0_0001);
        fetch("rstld.rd52", 32'd52, 32'hC0C0_0005);
        fetch("rstld.rd56", 32'd56, 32'hC0C0_0006);
        fetch("rstld.rd60", 32'd60, 32'hC0C0_0007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
